// File: rtl/axis_frame_arb_mux_if.sv
// Stream bundle for axis_frame_arb_mux: PORTS packed sources, one muxed sink
// and the grant status.
interface axis_frame_arb_mux_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(PORTS);

    logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata;
    logic [PORTS-1:0]            input_axis_tvalid;
    logic [PORTS-1:0]            input_axis_tready;
    logic [PORTS-1:0]            input_axis_tlast;
    logic [PORTS-1:0]            input_axis_tuser;
    logic [DATA_WIDTH-1:0]       output_axis_tdata;
    logic                        output_axis_tvalid;
    logic                        output_axis_tready;
    logic                        output_axis_tlast;
    logic                        output_axis_tuser;
    logic                        grant_valid;
    logic [IW-1:0]               grant_index;

    modport slave (
        input  input_axis_tdata,
        input  input_axis_tvalid,
        input  input_axis_tlast,
        input  input_axis_tuser,
        input  output_axis_tready,
        output input_axis_tready,
        output output_axis_tdata,
        output output_axis_tvalid,
        output output_axis_tlast,
        output output_axis_tuser,
        output grant_valid,
        output grant_index
    );

    modport master (
        output input_axis_tdata,
        output input_axis_tvalid,
        output input_axis_tlast,
        output input_axis_tuser,
        output output_axis_tready,
        input  input_axis_tready,
        input  output_axis_tdata,
        input  output_axis_tvalid,
        input  output_axis_tlast,
        input  output_axis_tuser,
        input  grant_valid,
        input  grant_index
    );
endinterface

// File: rtl/axis_frame_arb_mux.sv
// Frame-hold round-robin AXI4-Stream arbiter/mux with one output register.
// Define AXIS_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module axis_frame_arb_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    axis_frame_arb_mux_if.slave bus
);
    localparam int IW = $clog2(PORTS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic                  grant_valid;
    logic [IW-1:0]         grant_index;
    logic [IW-1:0]         last_grant;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_user;

    logic [PORTS-1:0]      req;
    logic [IW-1:0]         first;
    logic [IW-1:0]         winner;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic                  take;
    logic                  xfer;
    logic [PORTS-1:0]      onehot;

    assign req = bus.input_axis_tvalid;

    always_comb begin
        first = '0;
        for (int i = PORTS - 1; i >= 0; i--)
            if (req[i]) first = IW'(i);
    end

`ifdef AXIS_ARB_FIXED_PRIORITY_EN
    assign winner = first;
`else
    logic [IW-1:0] above;
    logic          above_hit;

    // Lowest requester past last_grant wins; otherwise wrap to lowest overall.
    always_comb begin
        above     = '0;
        above_hit = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--)
            if (req[i] && (IW'(i) > last_grant)) begin
                above     = IW'(i);
                above_hit = 1'b1;
            end
    end

    assign winner = above_hit ? above : first;
`endif

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < PORTS; i++)
            if (grant_index == IW'(i)) begin
                sel_data  = bus.input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = bus.input_axis_tvalid[i];
                sel_last  = bus.input_axis_tlast[i];
                sel_user  = bus.input_axis_tuser[i];
            end
    end

    // Accept a beat only when the output register is free or draining.
    assign take   = (state == ACTIVE) &&
                    (bus.output_axis_tready || !out_valid);
    assign xfer   = take && sel_valid;
    assign onehot = {{(PORTS-1){1'b0}}, 1'b1} << grant_index;

    assign bus.input_axis_tready  = take ? onehot : '0;
    assign bus.output_axis_tdata  = out_data;
    assign bus.output_axis_tvalid = out_valid;
    assign bus.output_axis_tlast  = out_last;
    assign bus.output_axis_tuser  = out_user;
    assign bus.grant_valid        = grant_valid;
    assign bus.grant_index        = grant_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            last_grant  <= IW'(PORTS - 1);
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_user    <= 1'b0;
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_user  <= sel_user;
                out_valid <= 1'b1;
            end else if (bus.output_axis_tready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state       <= ACTIVE;
                        grant_valid <= 1'b1;
                        grant_index <= winner;
                        last_grant  <= winner;
                    end
                end
                ACTIVE: begin
                    if (xfer && sel_last) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Bench for axis_frame_arb_mux: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axis_frame_arb_mux;
    localparam int P  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_frame_arb_mux_if #(.PORTS(P), .DATA_WIDTH(DW)) bus ();

    axis_frame_arb_mux #(.PORTS(P), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    beat_t      srcq[P][$];
    logic [P-1:0] stall = '0;
    logic       ordy = 1'b1;

    int    m_owner = -1;
    int    m_last = P - 1;
    beat_t ob[$];
    int    m_grants[$];

    beat_t dut_out[$];
    int    dut_grants[$];
    int    dut_gcyc[$];
    logic  prev_gv = 1'b0;
    int    first_vcyc = -1;
    bit    chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int gqi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic beat_t gqb(input beat_t q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    function automatic logic [P-1:0] m_tready();
        logic [P-1:0] r;
        r = '0;
        if (m_owner >= 0 && (ordy || ob.size() == 0)) r[m_owner] = 1'b1;
        return r;
    endfunction

    function automatic int pick(input logic [P-1:0] v);
`ifdef AXIS_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < P; i++)
            if (v[i]) return i;
`else
        for (int k = 1; k <= P; k++)
            if (v[(m_last + k) % P]) return (m_last + k) % P;
`endif
        return -1;
    endfunction

    task automatic model_step();
        logic [P-1:0] v;
        logic [P-1:0] tr;
        beat_t b;
        v = bus.input_axis_tvalid;
        if (rst) begin
            m_owner = -1;
            m_last = P - 1;
            ob.delete();
            return;
        end
        tr = m_tready();
        if (m_owner >= 0 && v[m_owner] && tr[m_owner]) begin
            b = srcq[m_owner].pop_front();
            ob.delete();
            ob.push_back(b);
            if (b.l) m_owner = -1;
        end else begin
            if (ordy) ob.delete();
            if (m_owner < 0 && v != '0) begin
                m_owner = pick(v);
                m_last = m_owner;
                m_grants.push_back(m_owner);
            end
        end
    endtask

    task automatic drive();
        logic [P*DW-1:0] d;
        logic [P-1:0] v, l, u;
        d = '0; v = '0; l = '0; u = '0;
        for (int p = 0; p < P; p++)
            if (srcq[p].size() > 0) begin
                d[p*DW +: DW] = srcq[p][0].d;
                l[p] = srcq[p][0].l;
                u[p] = srcq[p][0].u;
                v[p] = !stall[p];
            end
        bus.input_axis_tdata   = d;
        bus.input_axis_tvalid  = v;
        bus.input_axis_tlast   = l;
        bus.input_axis_tuser   = u;
        bus.output_axis_tready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1 drive();
    endtask

    task automatic push(input int p, input logic [7:0] d,
                        input logic l, input logic u);
        srcq[p].push_back({d, l, u});
    endtask

    task automatic clr_logs();
        dut_out.delete();
        dut_grants.delete();
        dut_gcyc.delete();
        m_grants.delete();
        first_vcyc = -1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int p = 0; p < P; p++) srcq[p].delete();
        stall = '0;
        ordy = 1'b1;
        drive();
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        drive();
        clr_logs();
    endtask

    task automatic run_idle(input int maxc, input string name);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < maxc) begin
            step();
            n++;
            busy = (m_owner >= 0) || (ob.size() > 0);
            for (int p = 0; p < P; p++)
                if (srcq[p].size() > 0) busy = 1'b1;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: still busy after %0d cycles, required idle",
                     name, n);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [P-1:0] et;
        et = m_tready();
        if (chk_en) begin
            chk("grant_valid", bus.grant_valid, m_owner >= 0);
            if (m_owner >= 0) chk("grant_index", bus.grant_index, m_owner);
            chk("tready", bus.input_axis_tready, et);
            chk("out_valid", bus.output_axis_tvalid, ob.size() > 0);
            if (ob.size() > 0) begin
                chk("out_data", bus.output_axis_tdata, ob[0].d);
                chk("out_last", bus.output_axis_tlast, ob[0].l);
                chk("out_user", bus.output_axis_tuser, ob[0].u);
            end
            if (bus.output_axis_tvalid && ordy)
                dut_out.push_back({bus.output_axis_tdata,
                                   bus.output_axis_tlast,
                                   bus.output_axis_tuser});
            if (bus.grant_valid && !prev_gv) begin
                dut_grants.push_back(int'(bus.grant_index));
                dut_gcyc.push_back(cyc);
            end
            prev_gv = bus.grant_valid;
            if (bus.output_axis_tvalid && first_vcyc < 0) first_vcyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_g[6];
        logic [7:0] exp_d2[12];
        logic [7:0] exp_d1[3];
        logic exp_l1[3];

        drive();
        reset_dut();

        @(negedge clk);
        chk("rst grant_valid", bus.grant_valid, 0);
        chk("rst grant_index", bus.grant_index, 0);
        chk("rst out_valid", bus.output_axis_tvalid, 0);
        chk("rst out_data", bus.output_axis_tdata, 0);
        chk("rst out_last", bus.output_axis_tlast, 0);
        chk("rst out_user", bus.output_axis_tuser, 0);
        chk("rst tready", bus.input_axis_tready, 0);

        // single source, 3-beat frame on port 2
        reset_dut();
        push(2, 8'h11, 0, 0);
        push(2, 8'h22, 0, 0);
        push(2, 8'h33, 1, 0);
        drive();
        t0 = cyc;
        run_idle(50, "single");
        exp_d1 = '{8'h11, 8'h22, 8'h33};
        exp_l1 = '{1'b0, 1'b0, 1'b1};
        chk("t1 beats", dut_out.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1 data", gqb(dut_out, i).d, exp_d1[i]);
            chk("t1 last", gqb(dut_out, i).l, exp_l1[i]);
        end
        chk("t1 grant", gqi(dut_grants, 0), 2);
        chk("t1 model grant", gqi(m_grants, 0), 2);
        chk("t1 latency", first_vcyc - t0, 2);

        // round-robin fairness across ports 0,1,3
        reset_dut();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < P; p++)
                if (p != 2)
                    for (int b = 0; b < 2; b++)
                        push(p, 8'(p * 16 + f * 2 + b), b == 1, 0);
        drive();
        run_idle(200, "rr");
`ifdef AXIS_ARB_FIXED_PRIORITY_EN
        exp_g = '{0, 0, 1, 1, 3, 3};
        exp_d2 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11,
                   8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33};
`else
        exp_g = '{0, 1, 3, 0, 1, 3};
        exp_d2 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h30, 8'h31,
                   8'h02, 8'h03, 8'h12, 8'h13, 8'h32, 8'h33};
`endif
        chk("t2 beats", dut_out.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk("t2 data", gqb(dut_out, i).d, exp_d2[i]);
            chk("t2 last", gqb(dut_out, i).l, i % 2);
        end
        for (int i = 0; i < 6; i++) begin
            chk("t2 grant", gqi(dut_grants, i), exp_g[i]);
            chk("t2 model grant", gqi(m_grants, i), exp_g[i]);
        end
        for (int i = 1; i < 6; i++)
            chk("t2 grant spacing",
                gqi(dut_gcyc, i) - gqi(dut_gcyc, i - 1), 3);

        // downstream backpressure mid-frame
        reset_dut();
        for (int b = 0; b < 6; b++) push(1, 8'hA0 + 8'(b), b == 5, 0);
        drive();
        repeat (4) step();
        ordy = 1'b0;
        drive();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3 hold data", bus.output_axis_tdata, 8'hA2);
            chk("t3 hold valid", bus.output_axis_tvalid, 1);
            chk("t3 hold tready", bus.input_axis_tready, 0);
            step();
        end
        ordy = 1'b1;
        drive();
        run_idle(50, "bp");
        chk("t3 beats", dut_out.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t3 data", gqb(dut_out, i).d, 8'hA0 + 8'(i));

        // granted source stalls while another port requests
        reset_dut();
        for (int b = 0; b < 4; b++) push(1, 8'h40 + 8'(b), b == 3, 0);
        drive();
        repeat (3) step();
        stall[1] = 1'b1;
        push(0, 8'h50, 0, 0);
        push(0, 8'h51, 1, 0);
        drive();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 stall gv", bus.grant_valid, 1);
            chk("t4 stall gi", bus.grant_index, 1);
            step();
        end
        stall[1] = 1'b0;
        drive();
        run_idle(50, "stall");
        chk("t4 grant0", gqi(dut_grants, 0), 1);
        chk("t4 grant1", gqi(dut_grants, 1), 0);
        chk("t4 beats", dut_out.size(), 6);
        for (int i = 0; i < 4; i++)
            chk("t4 data p1", gqb(dut_out, i).d, 8'h40 + 8'(i));
        chk("t4 data p0a", gqb(dut_out, 4).d, 8'h50);
        chk("t4 data p0b", gqb(dut_out, 5).d, 8'h51);

        // tuser pass-through, then reset mid-frame
        reset_dut();
        push(3, 8'h60, 0, 0);
        push(3, 8'h61, 1, 1);
        drive();
        run_idle(50, "tuser");
        chk("t5 grant", gqi(dut_grants, 0), 3);
        chk("t5 user0", gqb(dut_out, 0).u, 0);
        chk("t5 user1", gqb(dut_out, 1).u, 1);
        chk("t5 last1", gqb(dut_out, 1).l, 1);
        for (int b = 0; b < 4; b++) push(3, 8'h70 + 8'(b), b == 3, 0);
        drive();
        repeat (3) step();
        push(0, 8'h80, 0, 0);
        push(0, 8'h81, 1, 0);
        drive();
        step();
        rst = 1'b1;
        drive();
        step();
        @(negedge clk);
        chk("t5 rst gv", bus.grant_valid, 0);
        chk("t5 rst gi", bus.grant_index, 0);
        chk("t5 rst ov", bus.output_axis_tvalid, 0);
        chk("t5 rst od", bus.output_axis_tdata, 0);
        chk("t5 rst ol", bus.output_axis_tlast, 0);
        chk("t5 rst ou", bus.output_axis_tuser, 0);
        chk("t5 rst tready", bus.input_axis_tready, 0);
        #1;
        rst = 1'b0;
        srcq[3].delete();
        clr_logs();
        drive();
        run_idle(50, "post rst");
        chk("t5 post grant", gqi(dut_grants, 0), 0);
        chk("t5 post beats", dut_out.size(), 2);
        chk("t5 post d0", gqb(dut_out, 0).d, 8'h80);
        chk("t5 post d1", gqb(dut_out, 1).d, 8'h81);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_frame_arb_mux.md
Name: axis_frame_arb_mux

Overview:
- Frame-level arbiter and multiplexer that shares one downstream AXI4-Stream sink, typically an axis_frame_fifo input, between PORTS upstream AXI4-Stream sources.
- A grant is held from the first beat of a frame until its tlast beat, so frames are never interleaved.
- Default arbitration is round-robin.
- Output is registered, with one register stage.

Parameters:
- PORTS, 4, number of input streams (2..16).
- DATA_WIDTH, 8, tdata width per stream.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- input_axis_tdata  in  PORTS*DATA_WIDTH  packed tdata; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- input_axis_tvalid  in  PORTS  per-port tvalid.
- input_axis_tready  out  PORTS  per-port tready.
- input_axis_tlast  in  PORTS  per-port tlast.
- input_axis_tuser  in  PORTS  per-port tuser (bad-frame flag), passed through.
- output_axis_tdata  out  DATA_WIDTH  muxed tdata.
- output_axis_tvalid  out  1  muxed tvalid.
- output_axis_tready  in  1  downstream ready.
- output_axis_tlast  out  1  muxed tlast.
- output_axis_tuser  out  1  muxed tuser.
- grant_valid  out  1  a frame grant is active.
- grant_index  out  $clog2(PORTS)  index of the granted port; valid when grant_valid=1.

Behaviour:
- Clocking and reset:
  - Single clock domain clk.
  - rst is synchronous and active-high.
  - Reset values: output_axis_tvalid=0, output_axis_tdata=0, output_axis_tlast=0, output_axis_tuser=0, grant_valid=0, grant_index=0, all input_axis_tready=0, round-robin pointer last_grant=PORTS-1 (so port 0 wins first).
- States:
  - IDLE: no grant.
    - If any input_axis_tvalid is 1, pick a winner: first set bit searching upward from last_grant+1, modulo PORTS.
    - Next cycle: grant_valid=1, grant_index=winner, last_grant=winner, go to ACTIVE.
    - If no tvalid is set, stay in IDLE.
  - ACTIVE: the granted port is connected.
    - input_axis_tready[grant_index] = output_axis_tready | ~output_axis_tvalid. All other tready bits are 0.
    - A beat transfers when the granted tvalid and tready are both 1.
    - On transfer, the output registers load tdata/tlast/tuser of the granted port and output_axis_tvalid becomes 1.
    - If the transferred beat has tlast=1: grant_valid becomes 0 next cycle and the state returns to IDLE.
- Output register:
  - When output_axis_tready=1 and no new beat is loaded, output_axis_tvalid clears to 0.
  - When output_axis_tvalid=1 and output_axis_tready=0, data is held stable.
- Latency:
  - Request seen in IDLE at cycle N; tready high at N+1; first beat on output at N+2.
  - One dead arbitration cycle between consecutive frames, even on the same port.
- Throughput: one beat per cycle within a frame while downstream is ready.
- Boundary conditions:
  - Granted source deasserts tvalid mid-frame: the grant is held and output_axis_tvalid drops once the register drains. There is no timeout.
  - Single-beat frame (tlast on the first beat): grant lasts exactly one transfer cycle.
  - Simultaneous requests: resolved purely by the round-robin order above.
  - Non-granted tvalid does not change the grant.
  - tvalid of a non-granted port may toggle freely; it is not a protocol error here.
  - Round-robin wraps from PORTS-1 to 0.
  - rst mid-frame: the frame is truncated downstream and the output beat is discarded. Downstream frame FIFOs tolerate this through tuser and reset.

Optional Feature:
- Macro: AXIS_ARB_FIXED_PRIORITY_EN.
- Defined: IDLE picks the lowest-index port with tvalid=1. last_grant is not used for selection.
- Undefined: round-robin as specified above.
- Frame-hold semantics, latency and all other behaviour are identical in both builds.

Test Plan:
- Single source: reset, then port 2 sends a 3-beat frame 0x11,0x22,0x33 (tlast on 0x33). Output shows 0x11,0x22,0x33 with tlast only on 0x33. grant_index=2. First output beat 2 cycles after tvalid.
- Round-robin fairness: ports 0,1,3 each continuously offer 2-beat frames. Grant order is 0,1,3,0,1,3. No beat interleaving. One idle cycle between frames.
- Backpressure: output_axis_tready held 0 for 5 cycles mid-frame. Output data is stable. Granted tready=0 after the register fills. Resumes with no loss or duplication.
- Source stall: granted port 1 drops tvalid for 4 cycles mid-frame while port 0 requests. Grant stays on 1 until tlast, then moves to 0.
- tuser pass-through and reset: port 3 frame with tuser=1 on tlast appears with output_axis_tuser=1. rst asserted mid-frame clears all outputs to 0 next cycle; next grant goes to port 0 (in the fixed-priority build, to the lowest requesting port).
